// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ==========================================================================
// dmem_arb_pkg : shared FSM type and lock-counter width for dmem_arbiter
// Rev 1.0
// ==========================================================================
package dmem_arb_pkg;

  localparam int LOCK_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ==========================================================================
// dmem_arb_pick : one-hot winner among requests, search starting at ptr
// Rev 1.0
// ==========================================================================
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // Step i of the search visits requester (ptr + i) mod NUM_REQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ==========================================================================
// dmem_arbiter : N-way data-memory arbiter with bounded grant locking.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority. Rev 1.0
// ==========================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [NUM_REQ-1:0]      lock_i,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0][31:0] wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic                    rvalid_o,
  output logic [1:0]              rid_o,
  output logic [31:0]             rdata_o,
  output logic                    mem_we,
  output logic [31:0]             mem_a,
  output logic [31:0]             mem_wd,
  input  logic [31:0]             mem_rd
);

  localparam logic [LOCK_CNT_W-1:0] c_lock_max = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t              r_state;
  logic [NUM_REQ-1:0]      r_owner_oh;
  logic [LOCK_CNT_W-1:0]   r_lock_cnt;
  logic                    r_excl;
  logic [31:0]             r_last_a;

  logic [1:0]              w_ptr;
  logic [NUM_REQ-1:0]      w_others;
  logic [NUM_REQ-1:0]      w_arb_req;
  logic [NUM_REQ-1:0]      w_pick;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [1:0]              w_idx;
  logic [31:0]             w_addr;
  logic [31:0]             w_wdata;
  logic                    w_any;
  logic                    w_lock_win;
  logic                    w_own_req;
  logic                    w_own_lock;
  logic [LOCK_CNT_W-1:0]   w_cnt_inc;

  // After a forced release the old owner sits out one round if anyone else waits.
  assign w_others  = req_i & ~r_owner_oh;
  assign w_arb_req = (r_excl && (|w_others)) ? w_others : req_i;

  dmem_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (w_arb_req),
    .ptr (w_ptr),
    .gnt (w_pick)
  );

  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      if (r_state == ST_ARB) w_gnt = w_pick;
      else                   w_gnt = req_i & r_owner_oh;
    end
  end

  always_comb begin
    w_idx   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_idx   = 2'(k);
        w_addr  = addr_i[k];
        w_wdata = wdata_i[k];
      end
    end
  end

  assign w_any      = |w_gnt;
  assign w_lock_win = |(lock_i & w_gnt);
  assign w_own_req  = |(req_i & r_owner_oh);
  assign w_own_lock = |(lock_i & r_owner_oh);
  assign w_cnt_inc  = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + 1'b1;

  assign gnt_o  = w_gnt;
  assign mem_we = |(we_i & w_gnt);
  assign mem_a  = w_any ? w_addr : r_last_a;
  assign mem_wd = w_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] c_last = 2'(NUM_REQ - 1);
  logic [1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_ARB && w_any) begin
      r_ptr <= (w_idx == c_last) ? 2'd0 : w_idx + 2'd1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARB;
      r_owner_oh <= '0;
      r_lock_cnt <= '0;
      r_excl     <= 1'b0;
      r_last_a   <= '0;
      rvalid_o   <= 1'b0;
      rid_o      <= '0;
      rdata_o    <= '0;
    end else begin
      r_excl   <= 1'b0;
      rvalid_o <= w_any & ~mem_we;
      if (w_any) r_last_a <= w_addr;
      if (w_any && !mem_we) begin
        rdata_o <= mem_rd;
        rid_o   <= w_idx;
      end
      case (r_state)
        ST_ARB: begin
          if (w_any) begin
            r_owner_oh <= w_gnt;
            if (w_lock_win) begin
              r_state    <= ST_LOCKED;
              r_lock_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (!w_own_req || !w_own_lock) begin
            r_state <= ST_ARB;
          end else begin
            r_lock_cnt <= w_cnt_inc;
            if (w_cnt_inc >= c_lock_max) begin
              r_state <= ST_ARB;
              r_excl  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule
`default_nettype wire
